// File: rtl/fp_norm_round_pipe_if.sv
// Handshake/data bundle for the FP normalize-and-round back end.
// master: the surrounding datapath (drives words in, accepts results).
// slave:  the normalize/round pipeline itself.
interface fp_norm_round_pipe_if #(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
);
  localparam int WIDTH = 1 + EXP_BITS + MANT_BITS;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_BITS-1:0]    in_exp;
  logic [MANT_BITS+4:0]   in_mant;   // {carry, hidden, fraction, G, R, S}
  logic [1:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_r;
  logic [3:0]             out_flags; // {overflow, underflow, inexact, zero}

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    input  in_ready, out_valid, out_r, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    output in_ready, out_valid, out_r, out_flags
  );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// Three-stage normalize / round / pack back end for the FP add/sub path.
// Stage 1 normalizes (carry right-shift or clamped leading-zero left-shift),
// stage 2 applies the rounding increment, stage 3 renormalizes, handles
// overflow/zero/inf-NaN passthrough and registers the packed result.
module fp_norm_round_pipe #(
  parameter  int EXP_BITS  = 8,
  parameter  int MANT_BITS = 23,
  localparam int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_norm_round_pipe_if.slave   bus
);
  localparam int STAGES = 3;
  localparam int NV     = MANT_BITS + 3;          // {hidden, fraction, G, R}
  localparam int LZW    = $clog2(NV + 1);
  localparam int SW     = (LZW > EXP_BITS) ? LZW : EXP_BITS;
  localparam logic [1:0] RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11;
  localparam logic [EXP_BITS:0] EMAX = {1'b0, {EXP_BITS{1'b1}}};

  typedef struct packed {
    logic                 sign;
    logic [1:0]           rm;
    logic                 spec;   // inf/NaN from upstream, passed through
    logic                 zero;   // exact zero input
    logic [EXP_BITS-1:0]  exp;    // exponent field (0 when subnormal)
    logic [MANT_BITS:0]   sig;    // {hidden, fraction}
    logic                 g, r, s;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic [1:0]           rm;
    logic                 spec;
    logic                 zero;
    logic [EXP_BITS-1:0]  exp;
    logic [MANT_BITS+1:0] sum;    // {carry, hidden, fraction} after increment
    logic                 inexact;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            ld1, ld2, ld3;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [WIDTH-1:0] r_d, r_q;
  logic [3:0]      f_d, f_q;

  // Stage k may load when it is empty or its word is moving on this cycle.
  always_comb begin
    ld3 = !vld_pipe[3] || bus.out_ready;
    ld2 = !vld_pipe[2] || ld3;
    ld1 = !vld_pipe[1] || ld2;
  end

  assign bus.in_ready  = ld1;
  assign bus.out_valid = vld_pipe[3];
  assign bus.out_r     = r_q;
  assign bus.out_flags = f_q;

  // Stage 1: leading-zero count and normalization shift.
  logic [NV-1:0]       nv, nv_sh;
  logic [LZW-1:0]      lz;
  logic [SW-1:0]       lz_w, lim, sh;
  always_comb begin
    nv = bus.in_mant[MANT_BITS+3:1];
    lz = LZW'(NV);
    for (int i = 0; i < NV; i++)
      if (nv[i]) lz = LZW'(NV - 1 - i);
    lz_w  = SW'(lz);
    // Never shift below exponent 1; what remains un-normalized is subnormal.
    lim   = (bus.in_exp == '0) ? '0 : SW'(bus.in_exp - 1'b1);
    sh    = (lz_w < lim) ? lz_w : lim;
    nv_sh = nv << sh;

    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    s1_d.rm   = bus.in_rm;
    s1_d.spec = &bus.in_exp;
    s1_d.zero = (bus.in_mant == '0);
    if (s1_d.spec) begin
      s1_d.exp = bus.in_exp;
      s1_d.sig = {1'b0, bus.in_mant[MANT_BITS+2:3]};
    end else if (bus.in_mant[MANT_BITS+4]) begin
      // Mantissa carry: shift right one, folding the dropped bit into sticky.
      s1_d.exp = bus.in_exp + 1'b1;
      s1_d.sig = bus.in_mant[MANT_BITS+4:4];
      s1_d.g   = bus.in_mant[3];
      s1_d.r   = bus.in_mant[2];
      s1_d.s   = bus.in_mant[1] | bus.in_mant[0];
    end else begin
      s1_d.exp = nv_sh[NV-1] ? (bus.in_exp - EXP_BITS'(sh)) : '0;
      s1_d.sig = nv_sh[NV-1:2];
      s1_d.g   = nv_sh[1];
      s1_d.r   = nv_sh[0];
      s1_d.s   = bus.in_mant[0];
    end
  end

  // Stage 2: pick the rounding increment and add it to the significand.
  logic inc;
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.rm      = s1_q.rm;
    s2_d.spec    = s1_q.spec;
    s2_d.zero    = s1_q.zero;
    s2_d.exp     = s1_q.exp;
    s2_d.inexact = s1_q.g | s1_q.r | s1_q.s;
    inc = 1'b0;
    case (s1_q.rm)
      RM_RNE:  inc = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = !s1_q.sign & s2_d.inexact;
      default: inc = s1_q.sign & s2_d.inexact;
    endcase
    if (s1_q.spec) inc = 1'b0;
    s2_d.sum = {1'b0, s1_q.sig} + (MANT_BITS+2)'(inc);
  end

  // Stage 3: renormalize after rounding, then pack specials/overflow/zero.
  logic [EXP_BITS:0]    e_fin;
  logic [MANT_BITS-1:0] frac_fin;
  logic                 ovf, uf, to_inf;
  always_comb begin
    if (s2_q.sum[MANT_BITS+1])
      e_fin = {1'b0, s2_q.exp} + 1'b1;
    else if (s2_q.sum[MANT_BITS] && s2_q.exp == '0)
      e_fin = (EXP_BITS+1)'(1);            // subnormal rounded into hidden
    else
      e_fin = {1'b0, s2_q.exp};
    frac_fin = s2_q.sum[MANT_BITS+1] ? '0 : s2_q.sum[MANT_BITS-1:0];
    ovf      = (e_fin >= EMAX);
    uf       = (e_fin == '0) && (frac_fin != '0) && s2_q.inexact;
    to_inf   = (s2_q.rm == RM_RNE) || (s2_q.rm == RM_RUP && !s2_q.sign) ||
               (s2_q.rm == RM_RDN && s2_q.sign);

    r_d = {s2_q.sign, e_fin[EXP_BITS-1:0], frac_fin};
    f_d = {1'b0, uf, s2_q.inexact, 1'b0};
    if (s2_q.spec) begin
      r_d = {s2_q.sign, {EXP_BITS{1'b1}}, s2_q.sum[MANT_BITS-1:0]};
      f_d = 4'b0000;
    end else if (s2_q.zero) begin
      r_d = {s2_q.sign, {(WIDTH-1){1'b0}}};
      f_d = 4'b0001;
    end else if (ovf) begin
      r_d = to_inf ? {s2_q.sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}}
                   : {s2_q.sign, {(EXP_BITS-1){1'b1}}, 1'b0, {MANT_BITS{1'b1}}};
      f_d = 4'b1010;
    end
  end

  // Valid bits advance with their stage loads; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (ld1) vld_pipe[1] <= bus.in_valid;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // Internal stage data only moves when a valid word enters the stage.
  always_ff @(posedge clk) begin
    if (ld1 && bus.in_valid) s1_q <= s1_d;
    if (ld2 && vld_pipe[1])  s2_q <= s2_d;
  end

  // Output register: cleared by reset, held stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      f_q <= '0;
    end else if (ld3 && vld_pipe[2]) begin
      r_q <= r_d;
      f_q <= f_d;
    end
  end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Directed bench for fp_norm_round_pipe (binary32 configuration).
module tb_fp_norm_round_pipe;
  localparam int EB = 8;
  localparam int MB = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_round_pipe_if #(.EXP_BITS(EB), .MANT_BITS(MB)) bus();

  fp_norm_round_pipe #(.EXP_BITS(EB), .MANT_BITS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [1:0]  rm;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tbl[20];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    bus.in_sign = tbl[k].sign;
    bus.in_exp  = tbl[k].exp;
    bus.in_mant = tbl[k].mant;
    bus.in_rm   = tbl[k].rm;
  endtask

  task automatic run_vec(input int k);
    int n;
    drive(k);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      step();
      n++;
    end
    chk($sformatf("v%0d_latency", k), 32'(n), 32'd3);
    chk($sformatf("v%0d_out_r", k), bus.out_r, tbl[k].r);
    chk($sformatf("v%0d_flags", k), 32'(bus.out_flags), 32'(tbl[k].f));
    step();
  endtask

  initial begin
    int acc, vcount;
    bit fire;
    logic [31:0] got[$];
    logic [31:0] exp4[4];
    int w4[4];

    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
    bus.in_mant = '0; bus.in_rm = 2'b00; bus.out_ready = 1'b0;

    //            sign exp   mant          rm     result        flags
    tbl[0]  = '{1'b0, 8'd127, 28'h4000000, 2'd0, 32'h3F800000, 4'h0}; // 1.0
    tbl[1]  = '{1'b0, 8'd127, 28'h8000000, 2'd0, 32'h40000000, 4'h0}; // carry
    tbl[2]  = '{1'b0, 8'd127, 28'h7FFFFFC, 2'd0, 32'h40000000, 4'h2}; // RNE tie, mant ovf
    tbl[3]  = '{1'b0, 8'd127, 28'h7FFFFFC, 2'd1, 32'h3FFFFFFF, 4'h2}; // RTZ same
    tbl[4]  = '{1'b0, 8'd127, 28'h0000004, 2'd0, 32'h33800000, 4'h0}; // cancellation
    tbl[5]  = '{1'b1, 8'd127, 28'h0000000, 2'd0, 32'h80000000, 4'h1}; // -0
    tbl[6]  = '{1'b0, 8'd254, 28'h8000000, 2'd0, 32'h7F800000, 4'hA}; // ovf RNE
    tbl[7]  = '{1'b0, 8'd254, 28'h8000000, 2'd1, 32'h7F7FFFFF, 4'hA}; // ovf RTZ
    tbl[8]  = '{1'b1, 8'd254, 28'h8000000, 2'd2, 32'hFF7FFFFF, 4'hA}; // ovf RUP neg
    tbl[9]  = '{1'b1, 8'd254, 28'h8000000, 2'd3, 32'hFF800000, 4'hA}; // ovf RDN neg
    tbl[10] = '{1'b1, 8'd255, 28'h000000F, 2'd0, 32'hFF800001, 4'h0}; // NaN passthrough
    tbl[11] = '{1'b0, 8'd127, 28'h4000001, 2'd2, 32'h3F800001, 4'h2}; // RUP sticky
    tbl[12] = '{1'b1, 8'd127, 28'h4000001, 2'd3, 32'hBF800001, 4'h2}; // RDN sticky neg
    tbl[13] = '{1'b0, 8'd127, 28'h4000004, 2'd0, 32'h3F800000, 4'h2}; // tie to even
    tbl[14] = '{1'b0, 8'd127, 28'h4000005, 2'd0, 32'h3F800001, 4'h2}; // above half
    tbl[15] = '{1'b0, 8'd1,   28'h2000000, 2'd0, 32'h00400000, 4'h0}; // exact subnormal
    tbl[16] = '{1'b0, 8'd1,   28'h2000004, 2'd0, 32'h00400000, 4'h6}; // underflow
    tbl[17] = '{1'b0, 8'd1,   28'h3FFFFFC, 2'd0, 32'h00800000, 4'h2}; // round into hidden
    tbl[18] = '{1'b0, 8'd3,   28'h0800000, 2'd0, 32'h00400000, 4'h0}; // clamped shift
    tbl[19] = '{1'b0, 8'd10,  28'h2000002, 2'd0, 32'h04800000, 4'h2}; // shift 1, R->G

    // Reset state.
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_r", bus.out_r, 32'd0);
    chk("rst_flags", 32'(bus.out_flags), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    for (int k = 0; k < 20; k++) run_vec(k);

    // Backpressure: four words, downstream stalled; rounding mode per word.
    w4   = '{2, 3, 0, 4};
    exp4 = '{32'h40000000, 32'h3FFFFFFF, 32'h3F800000, 32'h33800000};
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) begin drive(w4[acc]); bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      #1;
      fire = bus.in_ready && bus.in_valid;
      step();
      if (fire) acc++;
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head", bus.out_r, exp4[0]);
    step(); step();
    chk("bp_head_held", bus.out_r, exp4[0]);
    chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      if (acc < 4) begin drive(w4[acc]); bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      #1;
      fire = bus.in_ready && bus.in_valid;
      if (bus.out_valid) got.push_back(bus.out_r);
      step();
      if (fire) acc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_word%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, exp4[i]);
    chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with two words in flight: nothing may come out afterwards.
    bus.out_ready = 1'b1;
    drive(0); bus.in_valid = 1'b1; step();
    drive(1); step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_r", bus.out_r, 32'd0);
    rst_n = 1'b1;
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.out_valid) vcount++;
    end
    chk("mid_rst_stale", 32'(vcount), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_norm_round_pipe.md
# fp_norm_round_pipe

Pipelined, parametrised normalize-and-round back end for the FP add/sub datapath. It accepts a raw sign/exponent/extended-mantissa result from the adder, performs full leading-zero normalization, four-mode IEEE-754 rounding with guard/round/sticky, post-round renormalization and special-case packing, and returns a packed word plus exception flags. It sits between the mantissa adder stage and the result register, with valid/ready handshakes on both sides.

## Interface
- EXP_BITS, 8, exponent field width
- MANT_BITS, 23, stored fraction width (hidden bit excluded)
- WIDTH, 1+EXP_BITS+MANT_BITS, packed result width (derived, do not override)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_BITS  biased exponent of the hidden-bit position
- in_mant  in  MANT_BITS+5  {carry, hidden, fraction[MANT_BITS], G, R, S}
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_r  out  WIDTH  {sign, exp field, fraction}
- out_flags  out  4  {overflow, underflow, inexact, zero}

## Operation
- Stage 1 (normalize):
  - carry=1: shift right 1, exp+1, shifted-out S OR'ed into new S.
  - carry=0: LZC over {hidden, fraction, G, R}; shift = min(lz, in_exp-1) (0 if in_exp=0); exp -= shift; zeros shift into G/R, S unchanged.
  - Post-shift hidden=0 → subnormal, exp field 0.
- Stage 2 (round): inexact = G|R|S. Increment: RNE G&(R|S|lsb); RTZ 0; RUP !sign&inexact; RDN sign&inexact. Add on {hidden, fraction}, width MANT_BITS+2.
- Stage 3 (renormalize/pack):
  - Increment carry-out → fraction 0, exp+1.
  - Subnormal rounding into hidden → exp field 1.
- Overflow when final exp ≥ 2^EXP_BITS-1; overflow and inexact both set.
  - RNE → ±inf; RTZ → ±max finite.
  - RUP → +inf if positive, else −max finite; RDN mirrored.
- Underflow = exp field 0 & nonzero fraction & inexact.
- Zero = in_mant all zero → out_r = {in_sign, 0, 0}, flags 0001.
- in_exp all ones (inf/NaN from upstream): pass through {in_sign, all ones, in fraction}, no rounding, flags 0000.

## Timing
- Latency 3 cycles input handshake → out_valid; throughput 1/cycle when out_ready=1.
- Each stage holds valid bit v1..v3. Stage k loads when empty or its contents advance.
  - in_ready = !v1 | (v2 can load); combinational; no registered skid.
- Stalled stage holds data and valid stable; out_r/out_flags stable while out_valid & !out_ready.
- Simultaneous accept and emit in one cycle is legal; no bubble inserted.
- Reset, sampled at clk edge: v1..v3, out_valid, out_r, out_flags → 0; in_ready = 1 from first cycle after release.
- Reset mid-operation drops all in-flight words; nothing emitted afterwards for them.
- in_rm is captured with the word and travels with it; mode changes affect only later words.

## Test plan
- 1.0 (EXP_BITS 8, MANT_BITS 23): in_exp=127, hidden=1, rest 0, RNE → 3 cycles later out_r=0x3F800000, flags 0000.
- Carry: in_exp=127, carry=1, all other bits 0 → 0x40000000, flags 0000.
- RNE tie with mantissa overflow: in_exp=127, hidden=1, fraction all ones, G=1,R=0,S=0 → 0x40000000, inexact=1. Same with RTZ → 0x3FFFFFFF, inexact=1.
- Cancellation: in_exp=127, only G=1 → out_r=0x33800000, flags 0000. in_mant=0 → 0x00000000 (sign per in_sign), zero=1.
- Overflow: in_exp=254, carry=1, RNE → 0x7F800000, flags 1010. RTZ → 0x7F7FFFFF, flags 1010.
- Backpressure/reset: 4 back-to-back words with out_ready=0 → in_ready drops after 3 accepted; release → 4 results in order, none lost/duplicated. Assert rst_n=0 with 2 in flight → out_valid=0 next cycle, no stale output.
